// File: rtl/mem_io_bus.sv
// mem_io_bus: stalling, wait-state-configurable data-side bus controller that serves
// a byte-addressed RAM, IO output registers, a free-running timer and an input port.
module mem_io_bus #(
  parameter int               WIDTH       = 32,
  parameter int               DATA_DEPTH  = 8,
  parameter int               IO_SIZE     = 4,
  parameter logic [WIDTH-1:0] IO_BASE     = 32'h0001_0000,
  parameter int               WAIT_STATES = 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [WIDTH-1:0]         req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  input  logic [2:0]               req_len,
  input  logic                     req_read,
  input  logic                     req_write,
  output logic                     stall,
  output logic [WIDTH-1:0]         rdata,
  output logic                     err,
  output logic [IO_SIZE*WIDTH-1:0] io_out,
  input  logic [WIDTH-1:0]         io_in
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int               RAM_BYTES = 1 << DATA_DEPTH;
  localparam logic [3:0]       WS_INIT   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [WIDTH-1:0] TMR_IDX   = WIDTH'(IO_SIZE);
  localparam logic [WIDTH-1:0] IN_IDX    = WIDTH'(IO_SIZE + 1);

  // Replace only the byte lanes selected by mask.
  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_v,
                                                   input logic [WIDTH-1:0] new_v,
                                                   input logic [3:0]       mask);
    logic [WIDTH-1:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]       len_q, len_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] timer_q, timer_d;
  logic [WIDTH-1:0] io_q [IO_SIZE];
  logic [WIDTH-1:0] io_d [IO_SIZE];
  logic [7:0]       ram_q [RAM_BYTES];

  logic [1:0]            lane_s;
  logic [WIDTH-1:0]      widx_s;
  logic [DATA_DEPTH-3:0] ram_w_s;
  logic                  ram_hit_s;
  logic                  io_rgn_s;
  logic                  len_ok_s;
  logic                  misal_s;
  logic [3:0]            mask_s;
  logic [WIDTH-1:0]      wsh_s;
  logic                  err_s;
  logic                  done_s;
  logic                  do_wr_s;
  logic [WIDTH-1:0]      rword_s;
  logic [WIDTH-1:0]      sh_s;
  logic [WIDTH-1:0]      ld_s;

  // Address decode, lane mask and legality checks on the latched request.
  always_comb begin
    lane_s    = addr_q[1:0];
    ram_w_s   = addr_q[DATA_DEPTH-1:2];
    widx_s    = (addr_q - IO_BASE) >> 2;
    ram_hit_s = (addr_q[WIDTH-1:DATA_DEPTH] == '0);
    io_rgn_s  = !ram_hit_s && (addr_q >= IO_BASE) && (widx_s <= IN_IDX);
    len_ok_s  = 1'b1;
    misal_s   = 1'b0;
    mask_s    = 4'b0000;
    wsh_s     = wdata_q;
    case (len_q)
      3'b000, 3'b100: begin
        // Unsigned lengths only exist for loads.
        len_ok_s = (len_q == 3'b000) || !wr_q;
        mask_s   = 4'b0001 << lane_s;
        wsh_s    = {4{wdata_q[7:0]}};
      end
      3'b001, 3'b101: begin
        len_ok_s = (len_q == 3'b001) || !wr_q;
        misal_s  = addr_q[0];
        mask_s   = 4'b0011 << lane_s;
        wsh_s    = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        misal_s = (lane_s != 2'b00);
        mask_s  = 4'b1111;
      end
      default: begin
        len_ok_s = 1'b0;
      end
    endcase
    err_s   = !(ram_hit_s || io_rgn_s) || misal_s || !len_ok_s;
    done_s  = (state_q == S_DONE);
    do_wr_s = done_s && wr_q && !err_s;
  end

  // Source word selection and load extraction.
  always_comb begin
    rword_s = '0;
    if (ram_hit_s) begin
      rword_s = {ram_q[{ram_w_s, 2'd3}], ram_q[{ram_w_s, 2'd2}],
                 ram_q[{ram_w_s, 2'd1}], ram_q[{ram_w_s, 2'd0}]};
    end else if (io_rgn_s) begin
      if (widx_s == TMR_IDX) begin
        rword_s = timer_q;
      end else if (widx_s == IN_IDX) begin
        rword_s = io_in;
      end else begin
        for (int k = 0; k < IO_SIZE; k++) begin
          if (widx_s == WIDTH'(k)) begin
            rword_s = io_q[k];
          end else begin
            rword_s = rword_s;
          end
        end
      end
    end else begin
      rword_s = '0;
    end
    sh_s = rword_s >> {lane_s, 3'b000};
    case (len_q)
      3'b000:                 ld_s = {{(WIDTH-8){sh_s[7]}}, sh_s[7:0]};
      3'b100:                 ld_s = {{(WIDTH-8){1'b0}}, sh_s[7:0]};
      3'b001:                 ld_s = {{(WIDTH-16){sh_s[15]}}, sh_s[15:0]};
      3'b101:                 ld_s = {{(WIDTH-16){1'b0}}, sh_s[15:0]};
      3'b010:                 ld_s = sh_s;
      default:                ld_s = '0;
    endcase
  end

  assign stall = RST_N && (req_read || req_write) && (state_q != S_DONE);
  assign err   = done_s && err_s;
  assign rdata = (done_s && !err_s && !wr_q) ? ld_s : '0;

  // Request FSM plus next values of the timer and IO registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (req_read || req_write) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          len_d   = req_len;
          wr_d    = req_write;
          cnt_d   = WS_INIT;
          state_d = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A timer store wins over the increment for that one cycle.
    timer_d = (do_wr_s && io_rgn_s && (widx_s == TMR_IDX)) ?
              merge_lanes(timer_q, wsh_s, mask_s) : timer_q + 32'd1;
    for (int k = 0; k < IO_SIZE; k++) begin
      io_d[k] = (do_wr_s && io_rgn_s && (widx_s == WIDTH'(k))) ?
                merge_lanes(io_q[k], wsh_s, mask_s) : io_q[k];
    end
  end

  // State, request latch, timer and IO register flops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= 3'd0;
      wr_q    <= 1'b0;
      timer_q <= '0;
      for (int k = 0; k < IO_SIZE; k++) io_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      timer_q <= timer_d;
      for (int k = 0; k < IO_SIZE; k++) io_q[k] <= io_d[k];
    end
  end

  // RAM byte-lane writes; contents intentionally survive reset.
  always_ff @(posedge CLK) begin
    if (do_wr_s && ram_hit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_s[b]) ram_q[{ram_w_s, 2'(b)}] <= wsh_s[8*b +: 8];
      end
    end
  end

  // Flatten IO registers onto the output bus.
  always_comb begin
    io_out = '0;
    for (int k = 0; k < IO_SIZE; k++) io_out[k*WIDTH +: WIDTH] = io_q[k];
  end

endmodule

// File: tb/tb_mem_io_bus.sv
// Scoreboard bench for mem_io_bus: the driver queues expected DONE responses, a
// negedge monitor pops and compares them; extra instances cover 0 and 3 wait states.
module tb_mem_io_bus;

  localparam logic [31:0] IOB = 32'h0001_0000;
  localparam logic [31:0] TMR = 32'h0001_0010;
  localparam logic [31:0] INP = 32'h0001_0014;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        er;
    logic        chk_rd;
    int          width;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  req_addr, req_wdata, io_in;
  logic [2:0]   req_len;
  logic         req_read, req_write;
  logic         stall, err;
  logic [31:0]  rdata;
  logic [127:0] io_out;

  logic         a0_read, a3_read;
  logic         a0_stall, a3_stall, a0_err, a3_err;
  logic [31:0]  a0_rdata, a3_rdata;
  logic [127:0] a0_io, a3_io;

  int   checks = 0;
  int   errors = 0;
  int   run    = 0;
  exp_t sb_q[$];
  exp_t e;

  always #5 clk = ~clk;

  mem_io_bus #(.WAIT_STATES(1)) u_dut (
    .CLK(clk), .RST_N(rst_n), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_len(req_len), .req_read(req_read), .req_write(req_write), .stall(stall),
    .rdata(rdata), .err(err), .io_out(io_out), .io_in(io_in));

  mem_io_bus #(.WAIT_STATES(0)) u_ws0 (
    .CLK(clk), .RST_N(rst_n), .req_addr(INP), .req_wdata(32'd0),
    .req_len(3'b010), .req_read(a0_read), .req_write(1'b0), .stall(a0_stall),
    .rdata(a0_rdata), .err(a0_err), .io_out(a0_io), .io_in(io_in));

  mem_io_bus #(.WAIT_STATES(3)) u_ws3 (
    .CLK(clk), .RST_N(rst_n), .req_addr(INP), .req_wdata(32'd0),
    .req_len(3'b010), .req_read(a3_read), .req_write(1'b0), .stall(a3_stall),
    .rdata(a3_rdata), .err(a3_err), .io_out(a3_io), .io_in(io_in));

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Queue the expected response, drive the request and hold it until DONE.
  task automatic do_req(input string name, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [2:0] ln,
                        input logic [31:0] exp_rd, input logic exp_er, input logic chk_rd);
    exp_t x;
    int   n;
    x.name = name; x.rd = exp_rd; x.er = exp_er; x.chk_rd = chk_rd; x.width = 2;
    sb_q.push_back(x);
    req_read = rd; req_write = wr; req_addr = a; req_wdata = wd; req_len = ln;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 20);
    if (stall) begin
      checks++; errors++;
      $display("FAIL %s_timeout: stall still 1 after %0d cycles, required 0", name, n);
    end
    @(posedge clk); #1;
    req_read = 1'b0; req_write = 1'b0;
  endtask

  // Monitor: measure stall width and compare DONE-cycle outputs against the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else if (req_read || req_write) begin
      if (stall) begin
        run++;
      end else begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got response with empty queue, required none");
        end else begin
          e = sb_q.pop_front();
          if (e.chk_rd) check32({e.name, "_rdata"}, rdata, e.rd);
          check32({e.name, "_err"}, {31'd0, err}, {31'd0, e.er});
          check32({e.name, "_stall_width"}, run, e.width);
        end
        run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit exp0 [4];
    bit exp3 [10];
    exp0 = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp3 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0; req_read = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_len = 3'd0; io_in = 32'h5A5A_0001;
    a0_read = 1'b0; a3_read = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset_stall", {31'd0, stall}, 32'd0);
    check32("reset_rdata", rdata, 32'd0);
    check32("reset_err", {31'd0, err}, 32'd0);
    for (int k = 0; k < 4; k++) check32($sformatf("reset_io%0d", k), io_out[32*k +: 32], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_req("sw_ram10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'd0, 1'b0, 1'b0);
    do_req("lb_13",  1'b1, 1'b0, 32'h13, 32'd0, 3'b000, 32'hFFFF_FFDE, 1'b0, 1'b1);
    do_req("lbu_13", 1'b1, 1'b0, 32'h13, 32'd0, 3'b100, 32'h0000_00DE, 1'b0, 1'b1);
    do_req("lh_10",  1'b1, 1'b0, 32'h10, 32'd0, 3'b001, 32'hFFFF_BEEF, 1'b0, 1'b1);
    do_req("lhu_12", 1'b1, 1'b0, 32'h12, 32'd0, 3'b101, 32'h0000_DEAD, 1'b0, 1'b1);
    do_req("lw_10",  1'b1, 1'b0, 32'h10, 32'd0, 3'b010, 32'hDEAD_BEEF, 1'b0, 1'b1);
    @(negedge clk);
    check32("idle_rdata", rdata, 32'd0);
    @(posedge clk); #1;

    do_req("sw_io1", 1'b0, 1'b1, IOB + 32'd4, 32'h1122_3344, 3'b010, 32'd0, 1'b0, 1'b0);
    do_req("sb_io5", 1'b0, 1'b1, IOB + 32'd5, 32'h0000_00AA, 3'b000, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check32("io1_merge", io_out[63:32], 32'h1122_AA44);
    check32("io0_untouched", io_out[31:0], 32'd0);
    @(posedge clk); #1;
    do_req("lw_io1", 1'b1, 1'b0, IOB + 32'd4, 32'd0, 3'b010, 32'h1122_AA44, 1'b0, 1'b1);

    do_req("lw_mis11", 1'b1, 1'b0, 32'h11, 32'd0, 3'b010, 32'd0, 1'b1, 1'b1);
    do_req("sw_ram20", 1'b0, 1'b1, 32'h20, 32'h0102_0304, 3'b010, 32'd0, 1'b0, 1'b0);
    do_req("sh_mis21", 1'b0, 1'b1, 32'h21, 32'h0000_FFFF, 3'b001, 32'd0, 1'b1, 1'b0);
    do_req("lw_ram20", 1'b1, 1'b0, 32'h20, 32'd0, 3'b010, 32'h0102_0304, 1'b0, 1'b1);
    do_req("lw_unmap", 1'b1, 1'b0, 32'h0000_FF00, 32'd0, 3'b010, 32'd0, 1'b1, 1'b1);
    do_req("st_len100", 1'b0, 1'b1, IOB + 32'd8, 32'h0000_0055, 3'b100, 32'd0, 1'b1, 1'b0);
    do_req("ld_len011", 1'b1, 1'b0, 32'h20, 32'd0, 3'b011, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    check32("io2_after_illegal", io_out[95:64], 32'd0);
    @(posedge clk); #1;

    do_req("sw_timer", 1'b0, 1'b1, TMR, 32'hFFFF_FFFE, 3'b010, 32'd0, 1'b0, 1'b0);
    do_req("lw_timer_wrap", 1'b1, 1'b0, TMR, 32'd0, 3'b010, 32'h0000_0000, 1'b0, 1'b1);
    do_req("lw_timer_next", 1'b1, 1'b0, TMR, 32'd0, 3'b010, 32'h0000_0003, 1'b0, 1'b1);

    do_req("lw_in", 1'b1, 1'b0, INP, 32'd0, 3'b010, 32'h5A5A_0001, 1'b0, 1'b1);
    do_req("lh_in16", 1'b1, 1'b0, INP + 32'd2, 32'd0, 3'b001, 32'h0000_5A5A, 1'b0, 1'b1);
    do_req("sw_in", 1'b0, 1'b1, INP, 32'h1234_5678, 3'b010, 32'd0, 1'b0, 1'b0);
    do_req("lw_in_again", 1'b1, 1'b0, INP, 32'd0, 3'b010, 32'h5A5A_0001, 1'b0, 1'b1);
    do_req("rdwr_io3", 1'b1, 1'b1, IOB + 32'd12, 32'h0000_0077, 3'b010, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check32("io3_rdwr_write", io_out[127:96], 32'h0000_0077);

    // Abort a store mid-WAIT with reset; the timer must restart from zero.
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = IOB; req_wdata = 32'hCAFE_F00D; req_len = 3'b010;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check32("midreset_stall", {31'd0, stall}, 32'd0);
    for (int k = 0; k < 4; k++) check32($sformatf("midreset_io%0d", k), io_out[32*k +: 32], 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check32("midreset_io0_hold", io_out[31:0], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_req("timer_after_rst", 1'b1, 1'b0, TMR, 32'd0, 3'b010, 32'h0000_0002, 1'b0, 1'b1);
    do_req("timer_after_rst2", 1'b1, 1'b0, TMR, 32'd0, 3'b010, 32'h0000_0005, 1'b0, 1'b1);
    check32("io0_after_abort", io_out[31:0], 32'd0);

    // Back-to-back loads on the zero- and three-wait-state instances.
    @(posedge clk); #1;
    a0_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check32($sformatf("ws0_stall_c%0d", i), {31'd0, a0_stall}, {31'd0, exp0[i]});
      if (!exp0[i]) begin
        check32($sformatf("ws0_rdata_c%0d", i), a0_rdata, 32'h5A5A_0001);
        check32($sformatf("ws0_err_c%0d", i), {31'd0, a0_err}, 32'd0);
      end
    end
    @(posedge clk); #1;
    a0_read = 1'b0;
    a3_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check32($sformatf("ws3_stall_c%0d", i), {31'd0, a3_stall}, {31'd0, exp3[i]});
      if (!exp3[i]) begin
        check32($sformatf("ws3_rdata_c%0d", i), a3_rdata, 32'h5A5A_0001);
        check32($sformatf("ws3_err_c%0d", i), {31'd0, a3_err}, 32'd0);
      end
    end
    @(posedge clk); #1;
    a3_read = 1'b0;
    @(negedge clk);
    check32("ws3_idle_stall", {31'd0, a3_stall}, 32'd0);
    check32("scoreboard_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
